core_writeback: RTL and testbench
=================================

CORE_WRITEBACK -- requirements
Module: core_writeback

Interface
REQ-001 The block SHALL have port: clock  in  1  rising-edge clock.
REQ-002 The block SHALL have port: reset  in  1  reset, asynchronous, active-high.
REQ-003 The block SHALL have port: pipe_valid  in  1  in-order pipeline writeback request, MEM-stage result.
REQ-004 The block SHALL have ports: pipe_regnum  in  5; pipe_data  in  64; pipe destination register and value.
REQ-005 The block SHALL have port: lu_valid  in  1  long-latency unit (multi-cycle mul/div) result valid.
REQ-006 The block SHALL have ports: lu_regnum  in  5; lu_data  in  64; long-latency destination register and value.
REQ-007 The block SHALL have port: lu_ready  out  1  buffer can accept a long-latency result this cycle.
REQ-008 The block SHALL have ports: issue_valid  in  1; issue_regnum  in  5; long-latency op issued, marks its destination pending.
REQ-009 The block SHALL have port: pipe_stall  out  1  pipeline must hold its writeback this cycle.
REQ-010 The block SHALL have ports: W_regnum  out  5; W_data  out  64; write_enable  out  1; registered regfile write port, same meaning as the MEM_regs writeback fields.
REQ-011 The block SHALL have port: busy_mask  out  32  bit n set = register n has a pending long-latency write.
REQ-012 The block SHALL have parameters: FIFO depth, default 4, number of buffered long-latency results; starvation limit, default 7, cycles a buffered result waits before forcing a pipeline stall.

Function
REQ-013 Long-latency results SHALL be buffered in a FIFO of the configured depth; push occurs on lu_valid & lu_ready.
REQ-014 lu_ready SHALL be combinational and high exactly when FIFO count < depth; a push never occurs when full.
REQ-015 Pipeline requests SHALL have priority: if pipe_valid & !pipe_stall, the next-cycle outputs carry the pipe request.
REQ-016 The FIFO head SHALL pop when count > 0 and (pipe_valid = 0 or pipe_stall = 1); the next-cycle outputs carry the head.
REQ-017 There SHALL be no FIFO bypass: an entry pushed in cycle t is poppable no earlier than t+1, so lu accept -> write_enable latency is at least 2 cycles.
REQ-018 Pipe accept -> write_enable latency SHALL be exactly 1 cycle.
REQ-019 When no request is selected, write_enable SHALL be 0 and W_regnum/W_data SHALL hold their previous values.
REQ-020 A selected request with regnum 0 SHALL be consumed (popped or accepted) but SHALL produce write_enable = 0.
REQ-021 A 3-bit starvation counter SHALL increment each cycle count > 0 and no pop occurs; it SHALL clear on a pop or when count = 0.
REQ-022 pipe_stall SHALL be combinational and high exactly when count > 0 and the counter equals the starvation limit; the head pops in that cycle and the pipe request is not consumed.
REQ-023 On issue_valid with issue_regnum != 0, the corresponding busy_mask bit SHALL be set next cycle; issue_regnum = 0 SHALL be ignored.
REQ-024 A FIFO pop SHALL clear the busy_mask bit of its regnum next cycle; a same-cycle set and clear of the same bit SHALL leave it set.
REQ-025 Pipe writes SHALL NOT modify busy_mask; WAW ordering against pending registers is the issuing stage's responsibility via busy_mask.
REQ-026 FIFO pointers SHALL wrap modulo depth; simultaneous push and pop SHALL leave count unchanged.

Reset
REQ-027 On reset the block SHALL set write_enable = 0, W_regnum = 0, W_data = 0, busy_mask = 0, FIFO count/pointers = 0 and starvation counter = 0, asynchronously.
REQ-028 Reset mid-operation SHALL discard all buffered results without emitting writes; lu_ready SHALL be 1 and pipe_stall 0 immediately after reset.

Structure
REQ-029 Package structures SHALL hold wb_entry_t {regnum[4:0], data[63:0]}, WB_FIFO_DEPTH = 4 and WB_STARVE_LIMIT = 7.
REQ-030 The FIFO SHALL be a sub-module wb_fifo (push, pop, head, count, full, empty); arbitration, starvation and scoreboard logic SHALL live in core_writeback.

Verification
REQ-031 The bench SHALL cover: pipe_valid, regnum 5, data 0x1234 -> next cycle write_enable = 1, W_regnum = 5, W_data = 0x1234.
REQ-032 The bench SHALL cover: issue regnum 9, then lu_valid regnum 9, data 0xAB while pipe idle -> busy_mask[9] = 1 until the write; write_enable with regnum 9 two cycles after push; busy_mask[9] = 0 the following cycle.
REQ-033 The bench SHALL cover: four lu pushes while pipe_valid stays high -> lu_ready = 0 after the fourth; a fifth lu_valid is not accepted.
REQ-034 The bench SHALL cover: one buffered entry plus continuous pipe_valid -> pipe_stall = 1 on the cycle the counter reaches 7; the head is written next cycle; the held pipe request is written one cycle later.
REQ-035 The bench SHALL cover: pipe write to regnum 0 -> write_enable = 0; issue_regnum 0 -> busy_mask unchanged.
REQ-036 The bench SHALL cover: assert reset with 3 buffered entries -> no writes occur, and busy_mask = 0 and lu_ready = 1 immediately.

Source files
------------

// File: rtl/core_writeback_pkg.sv
// rtl/core_writeback_pkg.sv - shared types and defaults for the writeback arbiter
//
// Purpose: defines the buffered writeback entry, the default FIFO depth and
// starvation limit, and a helper that builds a one-hot register mask.
package core_writeback_pkg;

  localparam int WB_FIFO_DEPTH   = 4;
  localparam int WB_STARVE_LIMIT = 7;

  typedef struct packed {
    logic [4:0]  regnum;
    logic [63:0] data;
  } wb_entry_t;

  function automatic logic [31:0] reg_bit(input logic [4:0] regnum);
    reg_bit = 32'd1 << regnum;
  endfunction

endpackage

// File: rtl/core_writeback_wb_fifo.sv
// rtl/core_writeback_wb_fifo.sv - circular FIFO holding long-latency writeback results
//
// Purpose: DEPTH-entry FIFO with a combinational head (no bypass: a pushed
// entry becomes visible at the head on the following cycle).
// Ports:
//   clock, reset    rising-edge clock, asynchronous active-high reset
//   push_i          write push_data_i (ignored when full)
//   push_data_i     entry to store
//   pop_i           drop the head entry (ignored when empty)
//   head_o          oldest stored entry
//   count_o         number of stored entries
//   full_o, empty_o occupancy flags
module wb_fifo
  import core_writeback_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  wb_entry_t     push_data_i,
  input  logic          pop_i,
  output wb_entry_t     head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Explicit wrap so non-power-of-two depths stay modulo DEPTH.
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_ok) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (pop_ok)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/core_writeback.sv
// rtl/core_writeback.sv - regfile writeback arbiter between pipeline and long-latency unit
//
// Purpose: merges in-order pipeline results with buffered mul/div results onto
// one registered regfile write port; the pipeline wins unless a buffered
// result has waited STARVE_LIMIT cycles, then the pipeline is stalled once.
// Also tracks registers with pending long-latency writes in busy_mask.
// Ports:
//   clock, reset                      rising-edge clock, async active-high reset
//   pipe_valid/pipe_regnum/pipe_data  pipeline writeback request
//   pipe_stall                        pipeline must hold its request this cycle
//   lu_valid/lu_regnum/lu_data        long-latency result, lu_ready = accepted
//   issue_valid/issue_regnum          long-latency op issued (marks reg busy)
//   W_regnum/W_data/write_enable      registered regfile write port
//   busy_mask                         pending long-latency destinations
module core_writeback
  import core_writeback_pkg::*;
#(
  parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_regnum,
  input  logic [63:0] pipe_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_regnum,
  input  logic [63:0] lu_data,
  output logic        lu_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_regnum,
  output logic        pipe_stall,
  output logic [4:0]  W_regnum,
  output logic [63:0] W_data,
  output logic        write_enable,
  output logic [31:0] busy_mask
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [2:0] STARVE_LIM3 = 3'(STARVE_LIMIT);

  wb_entry_t     lu_entry, head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          push, pop, pipe_take, has_entry;

  logic [2:0]    starve_q, starve_d;
  logic [4:0]    regnum_q, regnum_d;
  logic [63:0]   data_q, data_d;
  logic          we_q, we_d;
  logic [31:0]   busy_q, busy_d;

  assign lu_entry  = '{regnum: lu_regnum, data: lu_data};
  assign has_entry = (fifo_count != '0);
  assign lu_ready  = !fifo_full;
  assign push      = lu_valid && lu_ready;

  // Starved head takes the port; the pipe request is held, not consumed.
  assign pipe_stall = has_entry && (starve_q == STARVE_LIM3);
  assign pop        = !fifo_empty && (!pipe_valid || pipe_stall);
  assign pipe_take  = pipe_valid && !pipe_stall;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (lu_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Register 0 is consumed like any other request but never written.
  always_comb begin
    we_d     = 1'b0;
    regnum_d = regnum_q;
    data_d   = data_q;
    if (pipe_take) begin
      we_d     = (pipe_regnum != 5'd0);
      regnum_d = pipe_regnum;
      data_d   = pipe_data;
    end else if (pop) begin
      we_d     = (head.regnum != 5'd0);
      regnum_d = head.regnum;
      data_d   = head.data;
    end
  end

  always_comb begin
    starve_d = starve_q + 3'd1;
    if (!has_entry || pop) starve_d = 3'd0;
  end

  // Set is applied after clear so a same-cycle issue keeps the bit pending.
  always_comb begin
    busy_d = busy_q;
    if (pop) busy_d = busy_d & ~reg_bit(head.regnum);
    if (issue_valid && issue_regnum != 5'd0) busy_d = busy_d | reg_bit(issue_regnum);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      regnum_q <= '0;
      data_q   <= '0;
      starve_q <= '0;
      busy_q   <= '0;
    end else begin
      we_q     <= we_d;
      regnum_q <= regnum_d;
      data_q   <= data_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end

  assign write_enable = we_q;
  assign W_regnum     = regnum_q;
  assign W_data       = data_q;
  assign busy_mask    = busy_q;

endmodule

// File: tb/tb_core_writeback.sv
// tb/tb_core_writeback.sv - directed scoreboard bench for core_writeback
module tb_core_writeback;
  import core_writeback_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        pipe_valid, lu_valid, issue_valid;
  logic [4:0]  pipe_regnum, lu_regnum, issue_regnum;
  logic [63:0] pipe_data, lu_data;
  logic        lu_ready, pipe_stall, write_enable;
  logic [4:0]  W_regnum;
  logic [63:0] W_data;
  logic [31:0] busy_mask;

  int        n_checks = 0;
  int        n_errors = 0;
  wb_entry_t exp_q[$];
  wb_entry_t mon_e;

  core_writeback dut (
    .clock        (clock),
    .reset        (reset),
    .pipe_valid   (pipe_valid),
    .pipe_regnum  (pipe_regnum),
    .pipe_data    (pipe_data),
    .lu_valid     (lu_valid),
    .lu_regnum    (lu_regnum),
    .lu_data      (lu_data),
    .lu_ready     (lu_ready),
    .issue_valid  (issue_valid),
    .issue_regnum (issue_regnum),
    .pipe_stall   (pipe_stall),
    .W_regnum     (W_regnum),
    .W_data       (W_data),
    .write_enable (write_enable),
    .busy_mask    (busy_mask)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    pipe_valid = 1'b0; pipe_regnum = '0; pipe_data = '0;
    lu_valid = 1'b0; lu_regnum = '0; lu_data = '0;
    issue_valid = 1'b0; issue_regnum = '0;
  endtask

  task automatic drive_pipe(input logic [4:0] r, input logic [63:0] d);
    pipe_valid = 1'b1; pipe_regnum = r; pipe_data = d;
  endtask

  task automatic drive_lu(input logic [4:0] r, input logic [63:0] d);
    lu_valid = 1'b1; lu_regnum = r; lu_data = d;
  endtask

  task automatic expect_write(input logic [4:0] r, input logic [63:0] d);
    exp_q.push_back('{regnum: r, data: d});
  endtask

  // Every write the DUT emits must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (write_enable) begin
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_errors++;
        $error("FAIL sb_unexpected: observed write reg %0d data %0h, expected none", W_regnum, W_data);
      end
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("sb_regnum", 64'(W_regnum), 64'(mon_e.regnum));
        chk("sb_data", W_data, mon_e.data);
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_we", 64'(write_enable), 64'd0);
    chk("rst_regnum", 64'(W_regnum), 64'd0);
    chk("rst_data", W_data, 64'd0);
    chk("rst_busy", 64'(busy_mask), 64'd0);
    chk("rst_lu_ready", 64'(lu_ready), 64'd1);
    chk("rst_stall", 64'(pipe_stall), 64'd0);
    reset = 1'b0;

    // Pipe write: one-cycle latency, then hold with write_enable low.
    drive_pipe(5'd5, 64'h1234);
    expect_write(5'd5, 64'h1234);
    #1;
    chk("a_stall", 64'(pipe_stall), 64'd0);
    tick();
    idle();
    chk("a_we", 64'(write_enable), 64'd1);
    chk("a_regnum", 64'(W_regnum), 64'd5);
    chk("a_data", W_data, 64'h1234);
    tick();
    chk("a_idle_we", 64'(write_enable), 64'd0);
    chk("a_hold_regnum", 64'(W_regnum), 64'd5);
    chk("a_hold_data", W_data, 64'h1234);

    // Issue r9, then its long-latency result with the pipe idle.
    issue_valid = 1'b1; issue_regnum = 5'd9;
    tick();
    idle();
    chk("b_busy_set", 64'(busy_mask), 64'h200);
    drive_lu(5'd9, 64'hAB);
    expect_write(5'd9, 64'hAB);
    #1;
    chk("b_lu_ready", 64'(lu_ready), 64'd1);
    tick();
    idle();
    chk("b_no_bypass_we", 64'(write_enable), 64'd0);
    chk("b_busy_pending", 64'(busy_mask), 64'h200);
    tick();
    chk("b_we", 64'(write_enable), 64'd1);
    chk("b_regnum", 64'(W_regnum), 64'd9);
    chk("b_data", W_data, 64'hAB);
    chk("b_busy_clear", 64'(busy_mask), 64'd0);
    tick();
    chk("b_idle_we", 64'(write_enable), 64'd0);

    // Register 0: pipe write suppressed, issue ignored.
    drive_pipe(5'd0, 64'hDEAD);
    issue_valid = 1'b1; issue_regnum = 5'd0;
    tick();
    idle();
    chk("c_r0_we", 64'(write_enable), 64'd0);
    chk("c_r0_busy", 64'(busy_mask), 64'd0);

    // Fill the FIFO behind a busy pipe; a fifth result must be refused.
    for (int k = 0; k < 4; k++) begin
      drive_pipe(5'(10 + k), 64'(32'h100 + k));
      expect_write(5'(10 + k), 64'(32'h100 + k));
      drive_lu(5'(20 + k), 64'(32'h200 + k));
      #1;
      chk("d_lu_ready_open", 64'(lu_ready), 64'd1);
      tick();
    end
    drive_pipe(5'd14, 64'h104);
    expect_write(5'd14, 64'h104);
    drive_lu(5'd25, 64'h999);
    #1;
    chk("d_lu_ready_full", 64'(lu_ready), 64'd0);
    chk("d_no_stall", 64'(pipe_stall), 64'd0);
    tick();
    idle();
    for (int k = 0; k < 4; k++) expect_write(5'(20 + k), 64'(32'h200 + k));
    repeat (5) tick();
    chk("d_drained_ready", 64'(lu_ready), 64'd1);

    // Starvation: one buffered entry against a continuous pipe stream.
    drive_pipe(5'd4, 64'h40);
    expect_write(5'd4, 64'h40);
    drive_lu(5'd3, 64'h33);
    #1;
    chk("e_stall_s0", 64'(pipe_stall), 64'd0);
    tick();
    lu_valid = 1'b0;
    for (int j = 1; j < 8; j++) begin
      drive_pipe(5'd4, 64'(32'h40 + j));
      expect_write(5'd4, 64'(32'h40 + j));
      #1;
      chk("e_stall_low", 64'(pipe_stall), 64'd0);
      tick();
    end
    drive_pipe(5'd4, 64'h48);
    expect_write(5'd3, 64'h33);
    #1;
    chk("e_stall_high", 64'(pipe_stall), 64'd1);
    tick();
    chk("e_head_we", 64'(write_enable), 64'd1);
    chk("e_head_regnum", 64'(W_regnum), 64'd3);
    chk("e_head_data", W_data, 64'h33);
    expect_write(5'd4, 64'h48);
    #1;
    chk("e_stall_released", 64'(pipe_stall), 64'd0);
    tick();
    idle();
    chk("e_held_regnum", 64'(W_regnum), 64'd4);
    chk("e_held_data", W_data, 64'h48);
    tick();

    // Reset with three buffered results: nothing may be written afterwards.
    for (int k = 0; k < 3; k++) begin
      drive_pipe(5'd1, 64'(32'h500 + k));
      expect_write(5'd1, 64'(32'h500 + k));
      drive_lu(5'(11 + k), 64'(32'h600 + k));
      issue_valid = 1'b1; issue_regnum = 5'(11 + k);
      tick();
    end
    idle();
    drive_pipe(5'd0, 64'h0);
    tick();
    idle();
    chk("f_busy_before", 64'(busy_mask), 64'h3800);
    chk("f_ready_before", 64'(lu_ready), 64'd1);
    reset = 1'b1;
    #1;
    chk("f_busy_rst", 64'(busy_mask), 64'd0);
    chk("f_ready_rst", 64'(lu_ready), 64'd1);
    chk("f_stall_rst", 64'(pipe_stall), 64'd0);
    chk("f_we_rst", 64'(write_enable), 64'd0);
    chk("f_data_rst", W_data, 64'd0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("f_no_write", 64'(write_enable), 64'd0);
    chk("f_ready_after", 64'(lu_ready), 64'd1);
    chk("sb_outstanding", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
